// File: rtl/mem_controller.sv
// Round-robin memory controller: serialises per-lane LSU read/write requests onto one
// external memory channel. Define MEM_CONTROLLER_WRITE_EN to include the write path.
`timescale 1ns/1ps
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready
);

  localparam int LANE_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_CONSUMERS - 1);

`ifdef MEM_CONTROLLER_WRITE_EN
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ_WAIT, RELAY} state_t;
`endif

  state_t                   state, state_next;
  logic [LANE_BITS-1:0]     rr_ptr, owner, grant_lane, scan_lane;
  logic [LANE_BITS:0]       scan_idx;
  logic [NUM_CONSUMERS-1:0] lane_req;
  logic                     grant_found, grant_is_read, owner_valid;
  logic                     grant_take, start_read, read_done, lane_release;

`ifdef MEM_CONTROLLER_WRITE_EN
  logic owner_is_write, start_write, write_done;

  // A lane holding both requests is granted its read first; the write waits for a later grant.
  assign lane_req      = consumer_read_valid | consumer_write_valid;
  assign grant_is_read = consumer_read_valid[grant_lane];
  assign owner_valid   = owner_is_write ? consumer_write_valid[owner] : consumer_read_valid[owner];
`else
  logic unused_write_inputs;

  assign lane_req             = consumer_read_valid;
  assign grant_is_read        = 1'b1;
  assign owner_valid          = consumer_read_valid[owner];
  assign unused_write_inputs  = ^{consumer_write_valid, consumer_write_address,
                                  consumer_write_data, mem_write_ready};
  assign mem_write_valid      = 1'b0;
  assign mem_write_address    = '0;
  assign mem_write_data       = '0;
  assign consumer_write_ready = '0;
`endif

  // First requesting lane at or after rr_ptr, wrapping around the lane count.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    scan_idx    = '0;
    scan_lane   = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scan_idx = {1'b0, rr_ptr} + (LANE_BITS+1)'(i);
      if (scan_idx >= (LANE_BITS+1)'(NUM_CONSUMERS))
        scan_idx = scan_idx - (LANE_BITS+1)'(NUM_CONSUMERS);
      scan_lane = scan_idx[LANE_BITS-1:0];
      if (!grant_found && lane_req[scan_lane]) begin
        grant_found = 1'b1;
        grant_lane  = scan_lane;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    grant_take   = 1'b0;
    start_read   = 1'b0;
    read_done    = 1'b0;
    lane_release = 1'b0;
`ifdef MEM_CONTROLLER_WRITE_EN
    start_write  = 1'b0;
    write_done   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant_found) begin
          grant_take = 1'b1;
          if (grant_is_read) begin
            start_read = 1'b1;
            state_next = READ_WAIT;
          end
`ifdef MEM_CONTROLLER_WRITE_EN
          else begin
            start_write = 1'b1;
            state_next  = WRITE_WAIT;
          end
`endif
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          read_done  = 1'b1;
          state_next = RELAY;
        end
      end
`ifdef MEM_CONTROLLER_WRITE_EN
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          write_done = 1'b1;
          state_next = RELAY;
        end
      end
`endif
      RELAY: begin
        if (!owner_valid) begin
          lane_release = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read datapath and arbitration pointer; read data persists per lane until its next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr              <= '0;
      owner               <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      if (grant_take)
        owner <= grant_lane;
      if (start_read) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= consumer_read_address[grant_lane];
      end
      if (read_done) begin
        mem_read_valid             <= 1'b0;
        consumer_read_data[owner]  <= mem_read_data;
        consumer_read_ready[owner] <= 1'b1;
      end
      if (lane_release) begin
        consumer_read_ready <= '0;
        rr_ptr              <= (owner == LAST_LANE) ? '0 : owner + 1'b1;
      end
    end
  end

`ifdef MEM_CONTROLLER_WRITE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_is_write       <= 1'b0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_write_ready <= '0;
    end else begin
      if (grant_take)
        owner_is_write <= start_write;
      if (start_write) begin
        mem_write_valid   <= 1'b1;
        mem_write_address <= consumer_write_address[grant_lane];
        mem_write_data    <= consumer_write_data[grant_lane];
      end
      if (write_done) begin
        mem_write_valid             <= 1'b0;
        consumer_write_ready[owner] <= 1'b1;
      end
      if (lane_release)
        consumer_write_ready <= '0;
    end
  end
`endif

endmodule
